// File: rtl/cmd_mem_loader_if.sv
// Host-side configuration and word-stream handshake for cmd_mem_loader.
// The master drives session config and host words; the slave is the loader.
interface cmd_mem_loader_if #(
  parameter int unsigned CORE_SEL_WIDTH = 2,
  parameter int unsigned CMD_ADDR_WIDTH = 8,
  parameter int unsigned MEM_WIDTH      = 32
);
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [CORE_SEL_WIDTH-1:0] cfg_core;
  logic [CMD_ADDR_WIDTH-1:0] cfg_addr;
  logic                      s_valid;
  logic                      s_ready;
  logic [MEM_WIDTH-1:0]      s_data;
  logic                      s_last;

  modport master (
    output cfg_valid, cfg_core, cfg_addr, s_valid, s_data, s_last,
    input  cfg_ready, s_ready
  );

  modport slave (
    input  cfg_valid, cfg_core, cfg_addr, s_valid, s_data, s_last,
    output cfg_ready, s_ready
  );
endinterface

// File: rtl/cmd_mem_loader.sv
// Assembles MEM_WIDTH host words into full commands written to one of N_CORES
// command memories. Optional CMD_LOADER_CHECKSUM_EN adds an XOR checksum output.
module cmd_mem_loader #(
  parameter int unsigned N_CORES        = 4,
  parameter int unsigned MEM_WIDTH      = 32,
  parameter int unsigned MEM_TO_CMD     = 4,
  parameter int unsigned CMD_ADDR_WIDTH = 8,
  parameter int unsigned CORE_SEL_WIDTH = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  cmd_mem_loader_if.slave                 host,
  output logic [N_CORES-1:0]              mem_write_enable,
  output logic [CMD_ADDR_WIDTH-1:0]       mem_write_addr,
  output logic [MEM_WIDTH*MEM_TO_CMD-1:0] mem_write_data,
  output logic                            busy,
  output logic                            done,
  output logic                            err_wrap,
  output logic [CMD_ADDR_WIDTH:0]         cmd_count
`ifdef CMD_LOADER_CHECKSUM_EN
  ,
  output logic [MEM_WIDTH-1:0]            checksum
`endif
);

  localparam int unsigned CMD_WIDTH = MEM_WIDTH * MEM_TO_CMD;
  localparam int unsigned IDX_W     = (MEM_TO_CMD > 1) ? $clog2(MEM_TO_CMD) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MEM_TO_CMD - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t                    state_q, state_d;
  logic [CORE_SEL_WIDTH-1:0] core_q;
  logic [CMD_ADDR_WIDTH-1:0] addr_q;
  logic [IDX_W-1:0]          idx_q;
  logic [CMD_WIDTH-1:0]      asm_q, asm_d;
  logic                      wrapped_q;

  logic                      cfg_ready, s_ready;
  logic                      cfg_take, xfer, cmd_done, drop_wrap, sess_end;
  logic [N_CORES-1:0]        en_d;

  assign host.cfg_ready = cfg_ready;
  assign host.s_ready   = s_ready;
  assign busy           = (state_q != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    s_ready   = 1'b0;
    cfg_take  = 1'b0;
    xfer      = 1'b0;
    cmd_done  = 1'b0;
    drop_wrap = 1'b0;
    sess_end  = 1'b0;
    asm_d     = asm_q;
    en_d      = '0;
    case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (host.cfg_valid) begin
          cfg_take = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        if (host.s_valid) begin
          xfer = 1'b1;
          if (wrapped_q) begin
            // Address space exhausted: drop the word and flush the rest of the session.
            drop_wrap = 1'b1;
            if (host.s_last) begin
              sess_end = 1'b1;
              state_d  = IDLE;
            end else begin
              state_d  = DRAIN;
            end
          end else begin
            // Chunks above idx are already zero, so this also zero-pads short commands.
            for (int unsigned i = 0; i < MEM_TO_CMD; i++) begin
              if (idx_q == IDX_W'(i)) asm_d[i*MEM_WIDTH +: MEM_WIDTH] = host.s_data;
            end
            cmd_done = (idx_q == IDX_LAST) || host.s_last;
            if (host.s_last) begin
              sess_end = 1'b1;
              state_d  = IDLE;
            end
          end
        end
      end
      DRAIN: begin
        s_ready = 1'b1;
        if (host.s_valid) begin
          xfer = 1'b1;
          if (host.s_last) begin
            sess_end = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    for (int unsigned i = 0; i < N_CORES; i++) begin
      en_d[i] = cmd_done && (core_q == CORE_SEL_WIDTH'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_q           <= '0;
      addr_q           <= '0;
      idx_q            <= '0;
      asm_q            <= '0;
      wrapped_q        <= 1'b0;
      mem_write_enable <= '0;
      mem_write_addr   <= '0;
      mem_write_data   <= '0;
      done             <= 1'b0;
      err_wrap         <= 1'b0;
      cmd_count        <= '0;
    end else begin
      mem_write_enable <= en_d;
      done             <= sess_end;
      if (cmd_done) begin
        mem_write_addr <= addr_q;
        mem_write_data <= asm_d;
      end
      if (cfg_take) begin
        core_q    <= host.cfg_core;
        addr_q    <= host.cfg_addr;
        idx_q     <= '0;
        asm_q     <= '0;
        wrapped_q <= 1'b0;
        err_wrap  <= 1'b0;
        cmd_count <= '0;
      end else if (xfer) begin
        if (drop_wrap) begin
          err_wrap <= 1'b1;
        end else if (cmd_done) begin
          asm_q     <= '0;
          idx_q     <= '0;
          addr_q    <= addr_q + 1'b1;
          cmd_count <= cmd_count + 1'b1;
          if (addr_q == '1) wrapped_q <= 1'b1;
        end else if (state_q == LOAD) begin
          asm_q <= asm_d;
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

`ifdef CMD_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         checksum <= '0;
    else if (cfg_take) checksum <= '0;
    else if (xfer)     checksum <= checksum ^ host.s_data;
  end
`endif

endmodule

// File: tb/tb_cmd_mem_loader.sv
// Self-checking bench for cmd_mem_loader: scoreboard of expected memory writes
// plus per-scenario status checks.
module tb_cmd_mem_loader;

  logic         clk;
  logic         reset;
  logic [3:0]   mem_write_enable;
  logic [7:0]   mem_write_addr;
  logic [127:0] mem_write_data;
  logic         busy, done, err_wrap;
  logic [8:0]   cmd_count;
`ifdef CMD_LOADER_CHECKSUM_EN
  logic [31:0]  checksum;
`endif

  typedef struct {
    logic [3:0]   en;
    logic [7:0]   addr;
    logic [127:0] data;
    logic         done;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  done_cnt = 0;

  cmd_mem_loader_if #(.CORE_SEL_WIDTH(2), .CMD_ADDR_WIDTH(8), .MEM_WIDTH(32)) host ();

  cmd_mem_loader #(
    .N_CORES(4), .MEM_WIDTH(32), .MEM_TO_CMD(4), .CMD_ADDR_WIDTH(8), .CORE_SEL_WIDTH(2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .host             (host),
    .mem_write_enable (mem_write_enable),
    .mem_write_addr   (mem_write_addr),
    .mem_write_data   (mem_write_data),
    .busy             (busy),
    .done             (done),
    .err_wrap         (err_wrap),
    .cmd_count        (cmd_count)
`ifdef CMD_LOADER_CHECKSUM_EN
    ,
    .checksum         (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (mem_write_enable != 4'b0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got en=%b addr=%h data=%h, required no write",
                   mem_write_enable, mem_write_addr, mem_write_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (mem_write_enable !== e.en || mem_write_addr !== e.addr ||
              mem_write_data !== e.data || done !== e.done) begin
            n_fail++;
            $display("FAIL write: got en=%b addr=%h data=%h done=%b, required en=%b addr=%h data=%h done=%b",
                     mem_write_enable, mem_write_addr, mem_write_data, done,
                     e.en, e.addr, e.data, e.done);
          end
        end
      end
    end
  end

  task automatic push_wr(input logic [3:0] en, input logic [7:0] addr,
                         input logic [127:0] data, input logic d);
    wr_t e;
    e.en = en; e.addr = addr; e.data = data; e.done = d;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Starts and ends on a negedge; holds cfg_valid until the handshake edge.
  task automatic send_cfg(input logic [1:0] core, input logic [7:0] addr);
    int n = 0;
    host.cfg_core  = core;
    host.cfg_addr  = addr;
    host.cfg_valid = 1'b1;
    while (!host.cfg_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      n_checks++; n_fail++;
      $display("FAIL cfg_timeout: cfg_ready stayed 0, required 1 within 20 cycles");
    end
    @(negedge clk);
    host.cfg_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] data, input logic last);
    int n = 0;
    host.s_data  = data;
    host.s_last  = last;
    host.s_valid = 1'b1;
    while (!host.s_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      n_checks++; n_fail++;
      $display("FAIL word_timeout: s_ready stayed 0, required 1 within 20 cycles");
    end
    @(negedge clk);
    host.s_valid = 1'b0;
    host.s_last  = 1'b0;
  endtask

  task automatic check_drained(input string name);
    idle(2);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_pending: got %0d writes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    n_checks++;
    if ({host.cfg_ready, host.s_ready, busy, done, err_wrap} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_status: got %b, required 10000",
               {host.cfg_ready, host.s_ready, busy, done, err_wrap});
    end
    n_checks++;
    if (mem_write_enable !== 4'b0 || mem_write_addr !== 8'h0 || mem_write_data !== 128'h0 ||
        cmd_count !== 9'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b addr=%h data=%h cnt=%h, required all 0",
               mem_write_enable, mem_write_addr, mem_write_data, cmd_count);
    end
    reset = 1'b0;
    idle(1);
    n_checks++;
    if ({host.cfg_ready, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release: got cfg_ready/busy=%b, required 10", {host.cfg_ready, busy});
    end
  endtask

  task automatic test_basic();
    int d0 = done_cnt;
    push_wr(4'b0010, 8'h10, {32'h3, 32'h2, 32'h1, 32'h0}, 1'b0);
    push_wr(4'b0010, 8'h11, {32'h7, 32'h6, 32'h5, 32'h4}, 1'b1);
    send_cfg(2'd1, 8'h10);
    n_checks++;
    if (busy !== 1'b1 || host.cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy: got busy=%b cfg_ready=%b, required 1 0", busy, host.cfg_ready);
    end
    for (int i = 0; i < 8; i++) send_word(32'(i), i == 7);
    check_drained("basic");
    n_checks++;
    if (cmd_count !== 9'd2) begin
      n_fail++; $display("FAIL basic_count: got %0d, required 2", cmd_count);
    end
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL basic_done: got %0d pulses, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_short_last();
    int d0 = done_cnt;
    push_wr(4'b0100, 8'h20, {32'h0, 32'h0, 32'hB, 32'hA}, 1'b1);
    send_cfg(2'd2, 8'h20);
    send_word(32'hA, 1'b0);
    send_word(32'hB, 1'b1);
    check_drained("short");
    n_checks++;
    if (cmd_count !== 9'd1 || done_cnt - d0 != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL short_status: got cnt=%0d done=%0d busy=%b, required 1 1 0",
               cmd_count, done_cnt - d0, busy);
    end
  endtask

  task automatic test_wrap();
    int d0 = done_cnt;
    push_wr(4'b0001, 8'hFF, {32'h103, 32'h102, 32'h101, 32'h100}, 1'b0);
    send_cfg(2'd0, 8'hFF);
    for (int i = 0; i < 5; i++) send_word(32'h100 + 32'(i), 1'b0);
    n_checks++;
    if (err_wrap !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_drain: got err_wrap=%b busy=%b, required 1 1", err_wrap, busy);
    end
    send_word(32'h105, 1'b1);
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL wrap_done_cycle: got done=%b, required 1", done);
    end
    check_drained("wrap");
    n_checks++;
    if (err_wrap !== 1'b1 || cmd_count !== 9'd1 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL wrap_status: got err_wrap=%b cnt=%0d done=%0d, required 1 1 1",
               err_wrap, cmd_count, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    send_cfg(2'd3, 8'h40);
    for (int i = 0; i < 3; i++) send_word(32'h11 + 32'(i), 1'b0);
    reset = 1'b1;
    idle(2);
    n_checks++;
    if (mem_write_enable !== 4'b0 || mem_write_addr !== 8'h0 || mem_write_data !== 128'h0 ||
        {busy, done, err_wrap} !== 3'b000 || cmd_count !== 9'h0 || host.cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_outputs: got en=%b addr=%h cnt=%h bde=%b rdy=%b, required 0 0 0 000 1",
               mem_write_enable, mem_write_addr, cmd_count, {busy, done, err_wrap}, host.cfg_ready);
    end
    reset = 1'b0;
    idle(1);
    push_wr(4'b1000, 8'h41, {32'h24, 32'h23, 32'h22, 32'h21}, 1'b1);
    send_cfg(2'd3, 8'h41);
    for (int i = 0; i < 4; i++) send_word(32'h21 + 32'(i), i == 3);
    check_drained("midreset");
  endtask

  task automatic test_ignore();
    host.s_valid = 1'b1;
    host.s_data  = 32'h55;
    idle(2);
    n_checks++;
    if (host.s_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_sready: got s_ready=%b busy=%b, required 0 0", host.s_ready, busy);
    end
    // cfg and word presented together in IDLE: only cfg is taken
    send_cfg(2'd1, 8'h30);
    host.s_valid = 1'b0;
    push_wr(4'b0010, 8'h30, {32'h4, 32'h3, 32'h2, 32'h1}, 1'b0);
    push_wr(4'b0010, 8'h31, {32'h0, 32'h0, 32'h6, 32'h5}, 1'b1);
    send_word(32'h1, 1'b0);
    host.cfg_valid = 1'b1; host.cfg_core = 2'd2; host.cfg_addr = 8'h99;
    n_checks++;
    if (host.cfg_ready !== 1'b0) begin
      n_fail++; $display("FAIL load_cfg_ready: got %b, required 0", host.cfg_ready);
    end
    idle(1);
    send_word(32'h2, 1'b0);
    host.cfg_valid = 1'b0;
    for (int i = 3; i <= 6; i++) send_word(32'(i), i == 6);
    check_drained("ignore");
    n_checks++;
    if (cmd_count !== 9'd2) begin
      n_fail++; $display("FAIL ignore_count: got %0d, required 2", cmd_count);
    end
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    push_wr(4'b0001, 8'h50, {32'h0, 32'h0, 32'hB2, 32'hB1}, 1'b1);
    push_wr(4'b0100, 8'h60, {32'hC4, 32'hC3, 32'hC2, 32'hC1}, 1'b1);
    send_cfg(2'd0, 8'h50);
    send_word(32'hB1, 1'b0);
    send_word(32'hB2, 1'b1);
    send_cfg(2'd2, 8'h60);
    for (int i = 1; i <= 4; i++) send_word(32'hC0 + 32'(i), i == 4);
    check_drained("b2b");
    n_checks++;
    if (done_cnt - d0 != 2 || cmd_count !== 9'd1) begin
      n_fail++;
      $display("FAIL b2b_status: got done=%0d cnt=%0d, required 2 1", done_cnt - d0, cmd_count);
    end
  endtask

`ifdef CMD_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    push_wr(4'b0010, 8'h70, {32'h8, 32'h4, 32'h2, 32'h1}, 1'b1);
    send_cfg(2'd1, 8'h70);
    n_checks++;
    if (checksum !== 32'h0) begin
      n_fail++; $display("FAIL csum_clear: got %h, required 0", checksum);
    end
    send_word(32'h1, 1'b0);
    send_word(32'h2, 1'b0);
    send_word(32'h4, 1'b0);
    send_word(32'h8, 1'b1);
    n_checks++;
    if (checksum !== 32'hF || done !== 1'b1) begin
      n_fail++; $display("FAIL csum_done: got csum=%h done=%b, required F 1", checksum, done);
    end
    check_drained("csum");
    n_checks++;
    if (checksum !== 32'hF) begin
      n_fail++; $display("FAIL csum_hold: got %h, required F", checksum);
    end
  endtask
`endif

  initial begin
    host.cfg_valid = 1'b0;
    host.cfg_core  = '0;
    host.cfg_addr  = '0;
    host.s_valid   = 1'b0;
    host.s_data    = '0;
    host.s_last    = 1'b0;
    test_reset();
    test_basic();
    test_short_last();
    test_wrap();
    test_reset_mid();
    test_ignore();
    test_back_to_back();
`ifdef CMD_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
